// File: rtl/axi_mem_responder.sv
// AXI4 subordinate serving one transaction at a time from a single-port SRAM mapped at BaseAddr.
// Optional atomic (ATOP) rejection path enabled with `define AXI_MEM_RESPONDER_ATOP_EN.
module axi_mem_responder #(
  parameter int unsigned AxiIdWidth   = 4,
  parameter int unsigned AxiAddrWidth = 64,
  parameter int unsigned AxiDataWidth = 64,
  parameter int unsigned MemAddrWidth = 14,
  parameter logic [63:0] BaseAddr     = 64'h8000_0000
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      aw_valid_i,
  output logic                      aw_ready_o,
  input  logic [AxiIdWidth-1:0]     aw_id_i,
  input  logic [AxiAddrWidth-1:0]   aw_addr_i,
  input  logic [7:0]                aw_len_i,
  input  logic [2:0]                aw_size_i,
  input  logic [1:0]                aw_burst_i,
`ifdef AXI_MEM_RESPONDER_ATOP_EN
  input  logic [5:0]                aw_atop_i,
`endif
  input  logic                      w_valid_i,
  output logic                      w_ready_o,
  input  logic [AxiDataWidth-1:0]   w_data_i,
  input  logic [AxiDataWidth/8-1:0] w_strb_i,
  input  logic                      w_last_i,
  output logic                      b_valid_o,
  input  logic                      b_ready_i,
  output logic [AxiIdWidth-1:0]     b_id_o,
  output logic [1:0]                b_resp_o,
  input  logic                      ar_valid_i,
  output logic                      ar_ready_o,
  input  logic [AxiIdWidth-1:0]     ar_id_i,
  input  logic [AxiAddrWidth-1:0]   ar_addr_i,
  input  logic [7:0]                ar_len_i,
  input  logic [2:0]                ar_size_i,
  input  logic [1:0]                ar_burst_i,
  output logic                      r_valid_o,
  input  logic                      r_ready_i,
  output logic [AxiIdWidth-1:0]     r_id_o,
  output logic [AxiDataWidth-1:0]   r_data_o,
  output logic [1:0]                r_resp_o,
  output logic                      r_last_o,
  output logic                      mem_req_o,
  output logic                      mem_we_o,
  output logic [MemAddrWidth-1:0]   mem_addr_o,
  output logic [AxiDataWidth/8-1:0] mem_be_o,
  output logic [AxiDataWidth-1:0]   mem_wdata_o,
  input  logic [AxiDataWidth-1:0]   mem_rdata_i
);

  typedef enum logic [2:0] {IDLE, WRITE, WRESP, RREQ, RDATA} state_t;

  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlverr = 2'b10;
  localparam logic [1:0] RespDecerr = 2'b11;
  localparam logic [1:0] BurstFixed = 2'b00;
  localparam logic [1:0] BurstWrap  = 2'b10;
  localparam logic [AxiAddrWidth-1:0] Base = AxiAddrWidth'(BaseAddr);
  localparam int unsigned WordShift = $clog2(AxiDataWidth/8);

  state_t                    state_q;
  logic [AxiIdWidth-1:0]     id_q;
  logic [AxiAddrWidth-1:0]   addr_q;
  logic [7:0]                len_q;
  logic [2:0]                size_q;
  logic [1:0]                burst_q;
  logic [7:0]                beat_q;
  logic                      err_dec_q;
  logic                      err_slv_q;
  logic                      last_write_q;
  logic [1:0]                r_resp_q;
  logic                      r_last_q;
  logic                      r_zero_q;
  logic                      r_held_q;
  logic [AxiDataWidth-1:0]   r_data_q;
  logic                      atop_active;
`ifdef AXI_MEM_RESPONDER_ATOP_EN
  logic [5:0]                atop_q;
  assign atop_active = |atop_q;
`else
  assign atop_active = 1'b0;
`endif

  // Handshakes: a transfer happens on any rising clk_i where valid and ready are both high;
  // valid never waits on ready, and our valids/payloads stay stable until accepted.
  logic grant_w, grant_r;
  assign grant_w    = aw_valid_i && (!ar_valid_i || !last_write_q);
  assign grant_r    = ar_valid_i && !grant_w;
  assign aw_ready_o = (state_q == IDLE) && grant_w;
  assign ar_ready_o = (state_q == IDLE) && grant_r;
  assign w_ready_o  = (state_q == WRITE);

  // Beat address decode: out of range below the base or past the last SRAM word.
  logic [AxiAddrWidth-1:0] word_idx;
  logic                    beat_oor;
  logic                    burst_bad;
  logic                    beat_ok;
  logic                    last_beat;
  logic [AxiAddrWidth-1:0] next_addr;
  logic [1:0]              rd_resp;
  logic                    w_hs;

  assign word_idx  = (addr_q - Base) >> WordShift;
  assign beat_oor  = (addr_q < Base) || (|word_idx[AxiAddrWidth-1:MemAddrWidth]);
  assign burst_bad = (burst_q == BurstWrap) || (size_q > 3'd3);
  assign beat_ok   = !beat_oor && !burst_bad && !atop_active;
  assign last_beat = (beat_q == len_q);
  assign next_addr = (burst_q == BurstFixed) ? addr_q
                                             : addr_q + (AxiAddrWidth'(1) << size_q);
  assign rd_resp   = atop_active ? RespSlverr :
                     beat_oor    ? RespDecerr :
                     burst_bad   ? RespSlverr : RespOkay;
  assign w_hs      = (state_q == WRITE) && w_valid_i;

  assign mem_req_o   = (w_hs && beat_ok) || ((state_q == RREQ) && beat_ok);
  assign mem_we_o    = w_hs && beat_ok;
  assign mem_addr_o  = word_idx[MemAddrWidth-1:0];
  assign mem_be_o    = mem_we_o ? w_strb_i : '0;
  assign mem_wdata_o = mem_we_o ? w_data_i : '0;

  assign b_valid_o = (state_q == WRESP);
  assign b_id_o    = id_q;
  assign b_resp_o  = atop_active ? RespSlverr :
                     err_dec_q   ? RespDecerr :
                     err_slv_q   ? RespSlverr : RespOkay;

  // SRAM data arrives in the first RDATA cycle; it is forwarded then and held from a register after.
  assign r_valid_o = (state_q == RDATA);
  assign r_id_o    = id_q;
  assign r_resp_o  = r_resp_q;
  assign r_last_o  = r_last_q;
  assign r_data_o  = (state_q != RDATA) ? '0 :
                     r_held_q           ? r_data_q :
                     r_zero_q           ? '0 : mem_rdata_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      id_q         <= '0;
      addr_q       <= Base;
      len_q        <= '0;
      size_q       <= '0;
      burst_q      <= '0;
      beat_q       <= '0;
      err_dec_q    <= 1'b0;
      err_slv_q    <= 1'b0;
      last_write_q <= 1'b0;
      r_resp_q     <= RespOkay;
      r_last_q     <= 1'b0;
      r_zero_q     <= 1'b0;
      r_held_q     <= 1'b0;
      r_data_q     <= '0;
`ifdef AXI_MEM_RESPONDER_ATOP_EN
      atop_q       <= '0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          beat_q    <= '0;
          err_dec_q <= 1'b0;
          err_slv_q <= 1'b0;
          if (grant_w) begin
            id_q    <= aw_id_i;
            addr_q  <= aw_addr_i;
            len_q   <= aw_len_i;
            size_q  <= aw_size_i;
            burst_q <= aw_burst_i;
`ifdef AXI_MEM_RESPONDER_ATOP_EN
            atop_q  <= aw_atop_i;
`endif
            state_q <= WRITE;
          end else if (grant_r) begin
            id_q    <= ar_id_i;
            addr_q  <= ar_addr_i;
            len_q   <= ar_len_i;
            size_q  <= ar_size_i;
            burst_q <= ar_burst_i;
`ifdef AXI_MEM_RESPONDER_ATOP_EN
            atop_q  <= '0;
`endif
            state_q <= RREQ;
          end
        end
        WRITE: begin
          if (w_valid_i) begin
            if (beat_oor) err_dec_q <= 1'b1;
            if (burst_bad || (w_last_i != last_beat)) err_slv_q <= 1'b1;
            addr_q <= next_addr;
            beat_q <= beat_q + 8'd1;
            if (last_beat) state_q <= WRESP;
          end
        end
        WRESP: begin
          if (b_ready_i) begin
            last_write_q <= 1'b1;
            state_q      <= IDLE;
`ifdef AXI_MEM_RESPONDER_ATOP_EN
            // Atomics that expect a read result get len+1 error beats before retiring.
            if (atop_q[5]) begin
              beat_q  <= '0;
              state_q <= RREQ;
            end
`endif
          end
        end
        RREQ: begin
          r_resp_q <= rd_resp;
          r_last_q <= last_beat;
          r_zero_q <= !beat_ok;
          r_held_q <= 1'b0;
          state_q  <= RDATA;
        end
        RDATA: begin
          if (!r_held_q) begin
            r_data_q <= r_data_o;
            r_held_q <= 1'b1;
          end
          if (r_ready_i) begin
            addr_q <= next_addr;
            beat_q <= beat_q + 8'd1;
            if (r_last_q) begin
              last_write_q <= 1'b0;
              state_q      <= IDLE;
            end else begin
              state_q <= RREQ;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
